// File: rtl/clkdiv_ctrl.sv
// Run/stop and reconfiguration controller for the board clock-enable divider.
// One shared period counter; divisor swaps and stops land on period boundaries.
module clkdiv_ctrl #(
  parameter int unsigned   W       = 31,
  parameter logic [W-1:0]  DEF_DIV = W'(50000000)
) (
  input  logic         clki,
  input  logic         rst_n,
  input  logic         run_req,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         clko,
  output logic         tick,
  output logic         busy,
  output logic         err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;
  localparam logic [1:0] STOP = 2'd3;

  logic [1:0]   r_state;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_div_act;
  logic [W-1:0] r_div_pend;
  logic         r_err;

  logic         w_term;
  logic         w_xfer;
  logic         w_load;
  logic [W-1:0] w_cnt_nxt;

  assign w_term    = (r_cnt == r_div_act);
  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_load    = w_xfer && (cfg_div != '0);
  // Wrap by compare so div_act = all-ones never relies on adder overflow.
  assign w_cnt_nxt = w_term ? '0 : r_cnt + W'(1);

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_div_act  <= DEF_DIV;
      r_div_pend <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_xfer && (cfg_div == '0);
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_load)  r_div_act <= cfg_div;
          if (run_req) r_state   <= RUN;
        end
        RUN: begin
          r_cnt <= w_cnt_nxt;
          if (w_load) begin
            r_div_pend <= cfg_div;
            r_state    <= PEND;
          end else if (!run_req) begin
            r_state <= STOP;
          end
        end
        PEND: begin
          r_cnt <= w_cnt_nxt;
          if (w_term) begin
            r_div_act <= r_div_pend;
            r_state   <= run_req ? RUN : IDLE;
          end
        end
        STOP: begin
          // A returning run request resumes without disturbing the count.
          r_cnt <= w_cnt_nxt;
          if (run_req)     r_state <= RUN;
          else if (w_term) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign clko      = busy && (r_cnt <= (r_div_act >> 1));
  assign tick      = busy && (r_cnt == '0);
  assign cfg_ready = (r_state == IDLE) || (r_state == RUN);
  assign err       = r_err;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: vector table for steady-state behaviour,
// hand sequences for stop/resume and asynchronous reset mid-reconfiguration.
module tb_clkdiv_ctrl;
  localparam int W = 31;

  logic         clki = 1'b0;
  logic         rst_n = 1'b0;
  logic         run_req = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready, clko, tick, busy, err;

  int checks = 0;
  int errors = 0;

  clkdiv_ctrl #(.W(W), .DEF_DIV(31'd9)) dut (
    .clki(clki), .rst_n(rst_n), .run_req(run_req), .cfg_valid(cfg_valid),
    .cfg_div(cfg_div), .cfg_ready(cfg_ready), .clko(clko), .tick(tick),
    .busy(busy), .err(err)
  );

  always #5 clki = ~clki;

  typedef struct {
    logic         run;
    logic         cv;
    logic [W-1:0] div;
    logic         c, t, b, r, e;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic run, input logic cv, input logic [W-1:0] div,
                     input logic c, input logic t, input logic b, input logic r, input logic e);
    vec_t v;
    v.run = run; v.cv = cv; v.div = div;
    v.c = c; v.t = t; v.b = b; v.r = r; v.e = e;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic run, input logic cv = 1'b0, input logic [W-1:0] div = '0);
    run_req = run; cfg_valid = cv; cfg_div = div;
    @(posedge clki);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_clko"}, clko, 1'b0);
    chk({tag, "_tick"}, tick, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ready"}, cfg_ready, 1'b1);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  // Called at posedge+1; reset asserts and releases before the next edge.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Default divisor 9: period 10, clko high for cnt 0..4.
    add(1, 1,0,0, 1,1,1,1,0);
    add(4, 1,0,0, 1,0,1,1,0);
    add(5, 1,0,0, 0,0,1,1,0);
    add(1, 1,0,0, 1,1,1,1,0);
    // Offer div 5 at cnt 3; old period finishes, a zero offered in PEND is ignored.
    add(3, 1,0,0, 1,0,1,1,0);
    add(1, 1,1,5, 1,0,1,0,0);
    add(1, 1,0,0, 0,0,1,0,0);
    add(1, 1,1,0, 0,0,1,0,0);
    add(3, 1,0,0, 0,0,1,0,0);
    // New 6-cycle period: 1,1,1,0,0,0.
    add(1, 1,0,0, 1,1,1,1,0);
    add(2, 1,0,0, 1,0,1,1,0);
    add(3, 1,0,0, 0,0,1,1,0);
    add(1, 1,0,0, 1,1,1,1,0);
    // Illegal zero divisor in RUN: one-cycle err, period unchanged.
    add(1, 1,1,0, 1,0,1,1,1);
    add(1, 1,0,0, 1,0,1,1,0);
    add(3, 1,0,0, 0,0,1,1,0);
    add(1, 1,0,0, 1,1,1,1,0);
    // Stop at cnt 0: finishes the 6-cycle period, then idles.
    add(2, 0,0,0, 1,0,1,0,0);
    add(3, 0,0,0, 0,0,1,0,0);
    add(2, 0,0,0, 0,0,0,1,0);
    // Load div 3 in IDLE, then run: 1,1,0,0 repeating.
    add(1, 0,1,3, 0,0,0,1,0);
    for (int k = 0; k < 2; k++) begin
      add(1, 1,0,0, 1,1,1,1,0);
      add(1, 1,0,0, 1,0,1,1,0);
      add(2, 1,0,0, 0,0,1,1,0);
    end

    @(posedge clki);
    #1;
    chk_reset_outs("rst0");
    #4 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].run, tbl[i].cv, tbl[i].div);
      chk($sformatf("v%0d_clko", i), clko, tbl[i].c);
      chk($sformatf("v%0d_tick", i), tick, tbl[i].t);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].b);
      chk($sformatf("v%0d_ready", i), cfg_ready, tbl[i].r);
      chk($sformatf("v%0d_err", i), err, tbl[i].e);
    end

    // Stop requested at cnt 2: runs through cnt 9, then silent.
    pulse_reset("rst1");
    step(1);
    chk("s_first_tick", tick, 1'b1);
    step(1); step(1);
    for (int c = 3; c <= 9; c++) begin
      step(0);
      chk($sformatf("s_cnt%0d_clko", c), clko, (c <= 4));
      chk($sformatf("s_cnt%0d_busy", c), busy, 1'b1);
      chk($sformatf("s_cnt%0d_tick", c), tick, 1'b0);
    end
    step(0);
    chk("s_end_busy", busy, 1'b0);
    chk("s_end_clko", clko, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(0);
      chk("s_idle_tick", tick, 1'b0);
      chk("s_idle_busy", busy, 1'b0);
    end

    // Drop at cnt 2, re-raise at cnt 6: counting continues seamlessly.
    step(1);
    chk("r_tick0", tick, 1'b1);
    step(1); step(1);
    for (int i = 0; i < 4; i++) step(0);
    chk("r_stop_ready", cfg_ready, 1'b0);
    chk("r_stop_busy", busy, 1'b1);
    step(1);
    chk("r_cnt7_ready", cfg_ready, 1'b1);
    chk("r_cnt7_clko", clko, 1'b0);
    chk("r_cnt7_tick", tick, 1'b0);
    step(1); step(1);
    step(1);
    chk("r_wrap_tick", tick, 1'b1);
    chk("r_wrap_clko", clko, 1'b1);

    // Async reset mid-PEND at cnt 4: pending div 5 must be discarded.
    step(1); step(1);
    step(1, 1'b1, 31'd5);
    chk("p_ready", cfg_ready, 1'b0);
    step(1);
    pulse_reset("rst2");
    step(1);
    chk("p_tick0", tick, 1'b1);
    chk("p_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) step(1);
    chk("p_cnt3_clko", clko, 1'b1);
    for (int i = 0; i < 6; i++) step(1);
    chk("p_cnt9_tick", tick, 1'b0);
    chk("p_cnt9_clko", clko, 1'b0);
    step(1);
    chk("p_wrap_tick", tick, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
